// File: rtl/graph_pkg.sv
// Shared definitions for the edge-bundle interface: lane geometry, the bundle
// record carried through the bundle FIFO, and small lane helpers.
package graph_pkg;

    localparam int EDGE_W     = 96;
    localparam int LANES      = 8;
    localparam int LANE_IDX_W = 3;

    // Lane k of a packed lane array sits at bits [EDGE_W*(k+1)-1 : EDGE_W*k]
    typedef logic [LANES-1:0][EDGE_W-1:0] lane_data_t;

    typedef struct packed {
        lane_data_t       data;
        logic [LANES-1:0] mask;
        logic             last;
    } bundle_t;

    // One-hot select for the lane addressed by idx
    function automatic logic [LANES-1:0] laneSelect(input logic [LANE_IDX_W-1:0] idx);
        logic [LANES-1:0] sel;
        sel      = '0;
        sel[idx] = 1'b1;
        return sel;
    endfunction

    // Number of occupied lanes in a bundle mask
    function automatic logic [LANE_IDX_W:0] laneCount(input logic [LANES-1:0] mask);
        logic [LANE_IDX_W:0] n;
        n = '0;
        for (int k = 0; k < LANES; k++) begin
            n = n + {{LANE_IDX_W{1'b0}}, mask[k]};
        end
        return n;
    endfunction

endpackage

// File: rtl/bundle_fifo2.sv
// Two-entry bundle FIFO sitting between the packer and the resolver.
// Push and pop in the same cycle both advance their pointers and leave the
// occupancy unchanged. The head entry is always presented on head_o.
module bundle_fifo2
    import graph_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    push_i,
    input  bundle_t pushData_i,
    input  logic    pop_i,
    output bundle_t head_o,
    output logic [1:0] count_o
);

    bundle_t    mem_q [2];
    logic       wrPtr_q, wrPtr_d;
    logic       rdPtr_q, rdPtr_d;
    logic [1:0] count_q, count_d;
    logic       doPush, doPop;

    assign doPush = push_i && (count_q != 2'd2);
    assign doPop  = pop_i && (count_q != 2'd0);

    // Next pointer and occupancy values from the push/pop pair
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = ~wrPtr_q;
        end
        if (doPop) begin
            rdPtr_d = ~rdPtr_q;
        end
        if (doPush && !doPop) begin
            count_d = count_q + 2'd1;
        end else if (doPop && !doPush) begin
            count_d = count_q - 2'd1;
        end
    end

    // Pointer and occupancy registers; reset empties the FIFO
    always_ff @(posedge clk) begin
        if (!rst) begin
            wrPtr_q <= 1'b0;
            rdPtr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only observed while occupied, so no reset
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

    assign head_o  = mem_q[rdPtr_q];
    assign count_o = count_q;

endmodule

// File: rtl/edge_bundle_packer.sv
// Packs a stream of single edges into 8-lane bundles for the bank conflict
// resolver. A bundle closes when lane 7 fills or on an in_last edge, is queued
// in a 2-entry FIFO, and is held on the output until the resolver advances.
module edge_bundle_packer #(
    parameter int EDGE_W = graph_pkg::EDGE_W,
    parameter int LANES  = graph_pkg::LANES,
    parameter int CNT_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [EDGE_W-1:0]       in_data,
    input  logic                    in_last,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [EDGE_W*LANES-1:0] out_data,
    output logic [LANES-1:0]        out_mask,
    input  logic                    adv,
    output logic [CNT_W-1:0]        bundles_sent,
    output logic [CNT_W-1:0]        edges_sent,
    output logic                    done
);

    import graph_pkg::*;

    logic [LANE_IDX_W-1:0] laneCnt_q, laneCnt_d;
    lane_data_t            packData_q, packData_d;
    logic [LANES-1:0]      packMask_q, packMask_d;
    logic [CNT_W-1:0]      bundlesSent_q, bundlesSent_d;
    logic [CNT_W-1:0]      edgesSent_q, edgesSent_d;
    logic                  done_q, done_d;

    bundle_t    pushBundle;
    bundle_t    head;
    logic [1:0] fifoCount;
    logic       xfer;
    logic       complete;
    logic       retire;

    // Ready depends only on registered FIFO occupancy, never on adv
    assign in_ready  = (fifoCount != 2'd2);
    assign xfer      = in_valid && in_ready;
    assign out_valid = (fifoCount != 2'd0);
    assign retire    = adv && out_valid;

    // Merge the incoming edge into the packing register and decide whether it closes a bundle
    always_comb begin
        pushBundle                 = '0;
        pushBundle.data            = packData_q;
        pushBundle.data[laneCnt_q] = in_data;
        pushBundle.mask            = packMask_q | laneSelect(laneCnt_q);
        pushBundle.last            = in_last;
        complete                   = xfer && ((laneCnt_q == LANE_IDX_W'(LANES - 1)) || in_last);
        packData_d                 = packData_q;
        packMask_d                 = packMask_q;
        laneCnt_d                  = laneCnt_q;
        if (complete) begin
            packData_d = '0;
            packMask_d = '0;
            laneCnt_d  = '0;
        end else if (xfer) begin
            packData_d = pushBundle.data;
            packMask_d = pushBundle.mask;
            laneCnt_d  = laneCnt_q + 1'b1;
        end
    end

    // Packing register; reset discards any partial bundle
    always_ff @(posedge clk) begin
        if (!rst) begin
            laneCnt_q  <= '0;
            packData_q <= '0;
            packMask_q <= '0;
        end else begin
            laneCnt_q  <= laneCnt_d;
            packData_q <= packData_d;
            packMask_q <= packMask_d;
        end
    end

    // Retire statistics and the end-of-partition pulse
    always_comb begin
        bundlesSent_d = bundlesSent_q;
        edgesSent_d   = edgesSent_q;
        done_d        = 1'b0;
        if (retire) begin
            bundlesSent_d = bundlesSent_q + 1'b1;
            edgesSent_d   = edgesSent_q + {{(CNT_W - LANE_IDX_W - 1){1'b0}}, laneCount(head.mask)};
            done_d        = head.last;
        end
    end

    // Statistics registers; both counters wrap naturally at their width
    always_ff @(posedge clk) begin
        if (!rst) begin
            bundlesSent_q <= '0;
            edgesSent_q   <= '0;
            done_q        <= 1'b0;
        end else begin
            bundlesSent_q <= bundlesSent_d;
            edgesSent_q   <= edgesSent_d;
            done_q        <= done_d;
        end
    end

    bundle_fifo2 u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (complete),
        .pushData_i(pushBundle),
        .pop_i     (retire),
        .head_o    (head),
        .count_o   (fifoCount)
    );

    // An empty FIFO presents an all-zero bundle rather than stale storage
    assign out_data     = out_valid ? head.data : '0;
    assign out_mask     = out_valid ? head.mask : '0;
    assign bundles_sent = bundlesSent_q;
    assign edges_sent   = edgesSent_q;
    assign done         = done_q;

endmodule

// File: tb/tb_edge_bundle_packer.sv
// Bench for edge_bundle_packer: directed scenarios plus a long random run,
// all checked against a queue-based transaction model of the packer.
module tb_edge_bundle_packer;

    localparam int EW = 96;
    localparam int NL = 8;
    localparam int CW = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic [EW-1:0]    in_data;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic [EW*NL-1:0] out_data;
    logic [NL-1:0]    out_mask;
    logic             adv;
    logic [CW-1:0]    bundles_sent;
    logic [CW-1:0]    edges_sent;
    logic             done;

    always #5 clk = ~clk;

    edge_bundle_packer #(.EDGE_W(EW), .LANES(NL), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_mask    (out_mask),
        .adv         (adv),
        .bundles_sent(bundles_sent),
        .edges_sent  (edges_sent),
        .done        (done)
    );

    typedef struct {
        logic [EW*NL-1:0] data;
        logic [NL-1:0]    mask;
        bit               last;
    } bund_t;

    bund_t            fifoQ[$];
    logic [EW*NL-1:0] packData;
    logic [NL-1:0]    packMask;
    int               packCnt;
    logic [CW-1:0]    expBundles;
    logic [CW-1:0]    expEdges;
    logic             expDone;
    int               testsRun = 0;
    int               testsFailed = 0;

    function automatic int ones(input logic [NL-1:0] m);
        int n = 0;
        for (int k = 0; k < NL; k++) n += int'(m[k]);
        return n;
    endfunction

    function automatic logic [EW*NL-1:0] seqBundle(input int base);
        logic [EW*NL-1:0] v = '0;
        for (int k = 0; k < NL; k++) v[k*EW +: EW] = EW'(base + k);
        return v;
    endfunction

    task automatic modelClear();
        fifoQ.delete();
        packData   = '0;
        packMask   = '0;
        packCnt    = 0;
        expBundles = '0;
        expEdges   = '0;
        expDone    = 1'b0;
    endtask

    // Advance the model by one cycle using the current inputs, then clock the DUT
    task automatic tick(output bit xf);
        bit    ready;
        bit    nd;
        bund_t b;
        xf = 1'b0;
        if (!rst) begin
            modelClear();
        end else begin
            ready = (fifoQ.size() < 2);
            nd    = 1'b0;
            if (adv && fifoQ.size() != 0) begin
                nd         = fifoQ[0].last;
                expBundles = expBundles + 1;
                expEdges   = expEdges + CW'(ones(fifoQ[0].mask));
                void'(fifoQ.pop_front());
            end
            if (in_valid && ready) begin
                xf                        = 1'b1;
                packData[packCnt*EW +: EW] = in_data;
                packMask[packCnt]          = 1'b1;
                if (packCnt == NL - 1 || in_last) begin
                    b.data = packData;
                    b.mask = packMask;
                    b.last = in_last;
                    fifoQ.push_back(b);
                    packData = '0;
                    packMask = '0;
                    packCnt  = 0;
                end else begin
                    packCnt++;
                end
            end
            expDone = nd;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic resetDut();
        bit xf;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        adv      = 1'b0;
        tick(xf);
        rst = 1'b1;
    endtask

    // Stream n edges with ids base..base+n-1, bounded by a cycle budget
    task automatic sendEdges(input int n, input int base, input bit lastOnFinal);
        bit xf;
        int sent = 0;
        int cyc  = 0;
        while (sent < n) begin
            in_valid = 1'b1;
            in_data  = EW'(base + sent);
            in_last  = lastOnFinal && (sent == n - 1);
            tick(xf);
            if (xf) sent++;
            cyc++;
            if (cyc > 20 * n + 20) begin
                testsRun++;
                testsFailed++;
                $display("[TB] FAIL send_timeout: sent %0d edges, required %0d", sent, n);
                break;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        bit xf;
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; adv = 1'b0; in_data = '0;
        tick(xf);
        tick(xf);
        testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_valid: got %0b, want 0", out_valid); end
        testsRun++; if (in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_in_ready: got %0b, want 1", in_ready); end
        testsRun++; if (bundles_sent !== '0) begin testsFailed++; $display("[TB] FAIL reset_bundles: got %0d, want 0", bundles_sent); end
        testsRun++; if (edges_sent !== '0) begin testsFailed++; $display("[TB] FAIL reset_edges: got %0d, want 0", edges_sent); end
        testsRun++; if (done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done: got %0b, want 0", done); end
        testsRun++; if (out_mask !== '0) begin testsFailed++; $display("[TB] FAIL reset_mask: got %h, want 00", out_mask); end
        testsRun++; if (out_data !== '0) begin testsFailed++; $display("[TB] FAIL reset_data: got %h, want 0", out_data); end
        rst = 1'b1;
    endtask

    task automatic test_full_bundle();
        bit xf;
        resetDut();
        adv = 1'b1;
        for (int i = 0; i < NL; i++) begin
            in_valid = 1'b1;
            in_data  = EW'(i + 1);
            tick(xf);
            if (i == NL - 2) begin
                testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_early_valid: got %0b, want 0", out_valid); end
            end
        end
        in_valid = 1'b0;
        testsRun++; if (out_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL full_valid: got %0b, want 1", out_valid); end
        testsRun++; if (out_mask !== 8'hFF) begin testsFailed++; $display("[TB] FAIL full_mask: got %h, want ff", out_mask); end
        testsRun++; if (out_data !== seqBundle(1)) begin testsFailed++; $display("[TB] FAIL full_data: got %h, want %h", out_data, seqBundle(1)); end
        tick(xf);
        adv = 1'b0;
        testsRun++; if (bundles_sent !== 32'd1) begin testsFailed++; $display("[TB] FAIL full_bundles: got %0d, want 1", bundles_sent); end
        testsRun++; if (edges_sent !== 32'd8) begin testsFailed++; $display("[TB] FAIL full_edges: got %0d, want 8", edges_sent); end
        testsRun++; if (out_valid !== 1'b0) begin testsFailed++; $display("[TB] FAIL full_drained: got %0b, want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        bit xf;
        int sent = 0;
        int cyc  = 0;
        resetDut();
        for (int c = 0; c < 16; c++) begin
            in_valid = 1'b1;
            in_data  = EW'(sent + 1);
            tick(xf);
            if (xf) sent++;
        end
        testsRun++; if (in_ready !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_ready_low: got %0b, want 0", in_ready); end
        testsRun++; if (out_valid !== 1'b1) begin testsFailed++; $display("[TB] FAIL bp_valid: got %0b, want 1", out_valid); end
        in_data = EW'(17);
        for (int c = 0; c < 50; c++) begin
            tick(xf);
            testsRun++;
            if (out_data !== seqBundle(1) || out_mask !== 8'hFF || in_ready !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL bp_hold c%0d: got mask %h ready %0b lane0 %0d, want ff 0 1", c, out_mask, in_ready, out_data[EW-1:0]);
            end
        end
        adv = 1'b1;
        while (sent < 24 || fifoQ.size() != 0) begin
            in_valid = (sent < 24);
            in_data  = EW'(sent + 1);
            tick(xf);
            if (xf) sent++;
            cyc++;
            if (cyc > 200) begin
                testsRun++; testsFailed++;
                $display("[TB] FAIL bp_drain_timeout: sent %0d, want 24", sent);
                break;
            end
        end
        in_valid = 1'b0;
        adv      = 1'b0;
        testsRun++; if (bundles_sent !== 32'd3) begin testsFailed++; $display("[TB] FAIL bp_bundles: got %0d, want 3", bundles_sent); end
        testsRun++; if (edges_sent !== 32'd24) begin testsFailed++; $display("[TB] FAIL bp_edges: got %0d, want 24", edges_sent); end
    endtask

    task automatic test_partial_last();
        bit xf;
        int doneCnt = 0;
        resetDut();
        adv = 1'b1;
        for (int i = 0; i < 11; i++) begin
            in_valid = 1'b1;
            in_data  = EW'(200 + i);
            in_last  = (i == 10);
            tick(xf);
            if (done === 1'b1) doneCnt++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        testsRun++; if (out_mask !== 8'h07) begin testsFailed++; $display("[TB] FAIL tail_mask: got %h, want 07", out_mask); end
        testsRun++; if (out_data[EW*NL-1:3*EW] !== '0) begin testsFailed++; $display("[TB] FAIL tail_zero_lanes: got %h, want 0", out_data[EW*NL-1:3*EW]); end
        testsRun++; if (out_data[3*EW-1:2*EW] !== EW'(210)) begin testsFailed++; $display("[TB] FAIL tail_lane2: got %0d, want 210", out_data[3*EW-1:2*EW]); end
        for (int c = 0; c < 4; c++) begin
            tick(xf);
            if (done === 1'b1) doneCnt++;
        end
        adv = 1'b0;
        testsRun++; if (doneCnt !== 1) begin testsFailed++; $display("[TB] FAIL tail_done_pulses: got %0d, want 1", doneCnt); end
        testsRun++; if (edges_sent !== 32'd11) begin testsFailed++; $display("[TB] FAIL tail_edges: got %0d, want 11", edges_sent); end
        testsRun++; if (bundles_sent !== 32'd2) begin testsFailed++; $display("[TB] FAIL tail_bundles: got %0d, want 2", bundles_sent); end
    endtask

    task automatic test_lone_last();
        bit xf;
        resetDut();
        adv = 1'b1;
        tick(xf);
        tick(xf);
        adv = 1'b0;
        testsRun++; if (bundles_sent !== '0 || edges_sent !== '0) begin testsFailed++; $display("[TB] FAIL idle_adv_counters: got %0d/%0d, want 0/0", bundles_sent, edges_sent); end
        sendEdges(8, 300, 1'b0);
        sendEdges(1, 400, 1'b1);
        testsRun++; if (out_mask !== 8'hFF) begin testsFailed++; $display("[TB] FAIL lone_first_mask: got %h, want ff", out_mask); end
        adv = 1'b1;
        tick(xf);
        testsRun++; if (out_mask !== 8'h01) begin testsFailed++; $display("[TB] FAIL lone_mask: got %h, want 01", out_mask); end
        testsRun++; if (out_data !== (EW*NL)'(400)) begin testsFailed++; $display("[TB] FAIL lone_data: got %h, want 190", out_data); end
        tick(xf);
        adv = 1'b0;
        testsRun++; if (done !== 1'b1) begin testsFailed++; $display("[TB] FAIL lone_done: got %0b, want 1", done); end
        testsRun++; if (edges_sent !== 32'd9 || bundles_sent !== 32'd2) begin testsFailed++; $display("[TB] FAIL lone_counters: got %0d/%0d, want 2/9", bundles_sent, edges_sent); end
    endtask

    task automatic test_back_to_back();
        bit xf;
        resetDut();
        sendEdges(8, 500, 1'b0);
        sendEdges(7, 600, 1'b0);
        in_valid = 1'b1;
        in_data  = EW'(607);
        adv      = 1'b1;
        tick(xf);
        in_valid = 1'b0;
        adv      = 1'b0;
        testsRun++; if (out_valid !== 1'b1 || in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL b2b_count: got valid %0b ready %0b, want 1 1", out_valid, in_ready); end
        testsRun++; if (out_data !== seqBundle(600)) begin testsFailed++; $display("[TB] FAIL b2b_head: got %h, want %h", out_data, seqBundle(600)); end
        testsRun++; if (bundles_sent !== 32'd1) begin testsFailed++; $display("[TB] FAIL b2b_bundles: got %0d, want 1", bundles_sent); end
    endtask

    task automatic test_random();
        bit               xf;
        int               sent = 0;
        logic [EW*NL-1:0] eData;
        logic [NL-1:0]    eMask;
        resetDut();
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (sent < 1000) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = {$urandom, $urandom, $urandom};
                in_last  = ($urandom_range(0, 15) == 0);
                adv      = ($urandom_range(0, 2) != 0);
            end else begin
                in_valid = (packCnt != 0);
                in_data  = {$urandom, $urandom, $urandom};
                in_last  = 1'b1;
                adv      = 1'b1;
            end
            eData = (fifoQ.size() != 0) ? fifoQ[0].data : '0;
            eMask = (fifoQ.size() != 0) ? fifoQ[0].mask : '0;
            testsRun++;
            if (out_valid !== (fifoQ.size() != 0) || in_ready !== (fifoQ.size() < 2)) begin
                testsFailed++;
                $display("[TB] FAIL rand_handshake c%0d: got valid %0b ready %0b, want %0b %0b", cyc, out_valid, in_ready, fifoQ.size() != 0, fifoQ.size() < 2);
            end
            testsRun++;
            if (out_mask !== eMask || out_data !== eData) begin
                testsFailed++;
                $display("[TB] FAIL rand_head c%0d: got mask %h data %h, want %h %h", cyc, out_mask, out_data, eMask, eData);
            end
            testsRun++;
            if (bundles_sent !== expBundles || edges_sent !== expEdges || done !== expDone) begin
                testsFailed++;
                $display("[TB] FAIL rand_stats c%0d: got %0d/%0d done %0b, want %0d/%0d %0b", cyc, bundles_sent, edges_sent, done, expBundles, expEdges, expDone);
            end
            if (sent >= 1000 && packCnt == 0 && fifoQ.size() == 0 && !expDone) break;
            tick(xf);
            if (xf) sent++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        adv      = 1'b0;
        testsRun++;
        if (sent < 1000 || fifoQ.size() != 0) begin
            testsFailed++;
            $display("[TB] FAIL rand_timeout: sent %0d queued %0d, want >=1000 and 0", sent, fifoQ.size());
        end
    endtask

    task automatic test_mid_reset();
        bit xf;
        resetDut();
        adv = 1'b1;
        sendEdges(8, 700, 1'b0);
        tick(xf);
        adv = 1'b0;
        sendEdges(13, 710, 1'b0);
        rst = 1'b0;
        tick(xf);
        rst = 1'b1;
        testsRun++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL mid_rst_handshake: got valid %0b ready %0b, want 0 1", out_valid, in_ready); end
        testsRun++; if (bundles_sent !== '0 || edges_sent !== '0) begin testsFailed++; $display("[TB] FAIL mid_rst_counters: got %0d/%0d, want 0/0", bundles_sent, edges_sent); end
        adv = 1'b1;
        sendEdges(8, 800, 1'b0);
        testsRun++; if (out_mask !== 8'hFF) begin testsFailed++; $display("[TB] FAIL mid_rst_mask: got %h, want ff", out_mask); end
        testsRun++; if (out_data !== seqBundle(800)) begin testsFailed++; $display("[TB] FAIL mid_rst_data: got %h, want %h", out_data, seqBundle(800)); end
        tick(xf);
        adv = 1'b0;
        testsRun++; if (edges_sent !== 32'd8 || bundles_sent !== 32'd1) begin testsFailed++; $display("[TB] FAIL mid_rst_after: got %0d/%0d, want 1/8", bundles_sent, edges_sent); end
    endtask

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        adv      = 1'b0;
        modelClear();
        @(negedge clk);
        test_reset();
        test_full_bundle();
        test_backpressure();
        test_partial_last();
        test_lone_last();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, tests run %0d", testsRun);
        $fatal(1);
    end

endmodule

// File: doc/edge_bundle_packer.md
Name: edge_bundle_packer

Overview:
Transmit side of the 8-lane edge-bundle interface consumed by the bank conflict resolver. The block accepts a stream of single edges from the edge prefetch and DRAM read path, one edge per cycle. It packs the edges into 8-lane bundles and holds each bundle stable on its output until the resolver pulses its advance (inc) signal. A 2-entry bundle FIFO decouples packing from resolver stalls, and partial tail bundles are flushed on in_last.

Parameters:
EDGE_W, 96, edge width in bits.
LANES, 8, lanes per bundle (fixed at 8; the resolver is 8-wide).
CNT_W, 32, width of the statistics counters.

Ports:
clk  in  1  clock; all logic is on the rising edge.
rst  in  1  synchronous reset, active-low.
in_valid  in  1  upstream edge valid.
in_data  in  EDGE_W  upstream edge.
in_last  in  1  marks the final edge of the partition; qualified by in_valid.
in_ready  out  1  upstream may transfer; a transfer occurs on in_valid && in_ready.
out_valid  out  1  drives the resolver's input_valid.
out_data  out  EDGE_W*LANES  bundle; lane k occupies bits [EDGE_W*(k+1)-1 : EDGE_W*k].
out_mask  out  LANES  per-lane occupancy; bit k=1 means lane k holds a real edge.
adv  in  1  resolver inc; retires the current bundle.
bundles_sent  out  CNT_W  count of bundles retired.
edges_sent  out  CNT_W  count of real edges retired, equal to the popcount of out_mask at each retire.
done  out  1  one-cycle pulse on retire of the bundle that contains the in_last edge.

Behaviour:
- Reset (rst==0 at a clk edge) clears the following:
  - lane counter, packing register and mask, FIFO pointers and count;
  - bundles_sent, edges_sent, done, out_valid, out_mask;
  - out_data is driven to 0.
- Reset applied mid-operation discards all partial and queued bundles. No output is produced for them.
- Packing register:
  - lane_cnt counts 0..7.
  - On each transfer, in_data is written to lane lane_cnt, mask bit lane_cnt is set, and lane_cnt increments.
- A bundle is complete on a transfer with lane_cnt==7 or in_last==1. In that cycle:
  - the bundle (including the current edge) is pushed into the FIFO;
  - unfilled lanes have data 0 and mask 0;
  - a last flag is stored with the bundle;
  - the packing register clears and lane_cnt returns to 0.
- in_ready = (fifo_count < 2). It is derived from registered state only, with no combinational path from adv or in_valid.
- Output:
  - out_valid = (fifo_count != 0).
  - out_data and out_mask show the FIFO head.
  - The head is stable while out_valid is high and adv is low.
  - Latency is 1 cycle from the completing transfer to out_valid, when the FIFO was empty.
- Retire: adv && out_valid pops the head at the clk edge, and the next entry appears on the following cycle. adv while out_valid==0 is ignored and has no counter effect.
- Simultaneous push and pop: fifo_count is unchanged and the write and read pointers both advance. Push into a full FIFO cannot occur because in_ready is low.
- Counters:
  - On each retire, bundles_sent += 1 and edges_sent += popcount(head mask).
  - Both counters wrap modulo 2^CNT_W.
- done is registered and pulses high for one cycle after the retire of a bundle whose last flag is set.
- An in_last transfer with lane_cnt==0 produces a 1-lane bundle, mask 8'b0000_0001.
- in_last with in_valid==0 is ignored.

Decomposition:
- Shared package (graph_pkg): EDGE_W, LANES, the lane slice helper, and a bundle struct {data[LANES], mask, last}.
- One natural sub-module, bundle_fifo2: a 2-deep synchronous FIFO with count, push/pop and simultaneous push/pop support. The packing register, counters and done logic stay in the top level.

Test Plan:
- 8 edges (ids 1..8) streamed back-to-back, adv tied high → out_valid rises 1 cycle after the 8th transfer, with out_mask=8'hFF and lane k = id k+1. Retired next cycle; bundles_sent=1, edges_sent=8.
- 24 edges with adv held low → in_ready drops after the 16th transfer. FIFO holds 2 bundles and the head is stable for 50 cycles. Releasing adv drains both bundles, then accepts the remaining 8 (bundles_sent=3).
- 11 edges with in_last on the 11th → second bundle has mask 8'h07 and zeros in lanes 3..7. done pulses once after its retire; edges_sent=11.
- in_last on a lone edge after a full bundle → bundle with mask 8'h01. adv pulsed while out_valid=0 beforehand leaves the counters unchanged.
- Simultaneous push (completing transfer) and adv with fifo_count=1 → count stays 1. Ordering is preserved, checked against a scoreboard of 1000 random edges with random adv.
- rst=0 asserted for 1 cycle with one bundle queued and lane_cnt=5 → next cycle out_valid=0, in_ready=1, and the counters read 0. The next 8 edges form a clean bundle with mask 8'hFF.
